ins_bootloader: RTL and testbench
=================================

INS_BOOTLOADER -- requirements
Module: ins_bootloader

Interface
REQ-001 Parameter: MAX_WORDS, default 32, maximum instruction words accepted (instruction memory holds 64 bytes).
REQ-002 Parameter: BASE_ADDR, default 16'd0, byte address of the first instruction written.
REQ-003 Port: clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port: clear, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 Port: byte_in, input, 8, incoming boot stream byte.
REQ-006 Port: byte_valid, input, 1, byte_in holds a valid byte.
REQ-007 Port: byte_ready, output, 1, loader can accept a byte this cycle.
REQ-008 Port: ins_load, output, 16, instruction word for the instruction memory write port.
REQ-009 Port: l_addr, output, 16, byte address for the instruction memory write port.
REQ-010 Port: load, output, 1, one-cycle write strobe to instruction memory.
REQ-011 Port: cpu_hold, output, 1, high holds the processor PC and register writes frozen.
REQ-012 Port: done, output, 1, image loaded and checksum good.
REQ-013 Port: error, output, 1, image rejected (oversize count or checksum mismatch).

Function
REQ-014 Byte transfer SHALL occur only in a cycle where byte_valid and byte_ready are both high; byte_in is ignored otherwise.
REQ-015 Stream format: count high byte, count low byte (N, 16 bits), then 2N instruction bytes (each word high byte first), then one checksum byte.
REQ-016 States: CNT_HI, CNT_LO, INS_HI, INS_LO, WRITE, CSUM, DONE, ERR.
REQ-017 byte_ready SHALL be high in CNT_HI, CNT_LO, INS_HI, INS_LO and CSUM, and low in WRITE, DONE and ERR.
REQ-018 CNT_HI -> CNT_LO on transfer; CNT_LO -> ERR on transfer if N > MAX_WORDS, else -> CSUM if N == 0, else -> INS_HI.
REQ-019 INS_HI -> INS_LO on transfer, latching ins_load[15:8]; INS_LO -> WRITE on transfer, latching ins_load[7:0].
REQ-020 In WRITE, load SHALL be high for exactly one cycle, with ins_load and l_addr stable in that cycle.
REQ-021 WRITE -> INS_HI if words written < N, else -> CSUM.
REQ-022 l_addr SHALL equal BASE_ADDR at the first write and increase by 2 after each write (16-bit wrap; unreachable within MAX_WORDS).
REQ-023 Running checksum SHALL be the 8-bit XOR of all 2N instruction bytes; count bytes are excluded.
REQ-024 CSUM -> DONE on transfer if byte_in equals the running checksum, else -> ERR.
REQ-025 DONE and ERR are terminal until clear; further byte_valid SHALL be ignored.
REQ-026 done SHALL be high only in DONE; error SHALL be high only in ERR.
REQ-027 cpu_hold SHALL be high in every state except DONE; an image that ends in ERR keeps the processor held.
REQ-028 Latency from the transfer of the INS_LO byte to the load pulse SHALL be exactly one cycle; at most one byte is accepted per cycle.
REQ-029 load SHALL never be asserted outside WRITE.

Reset
REQ-030 clear high at a rising edge SHALL force state CNT_HI, checksum 0, word counter 0, l_addr BASE_ADDR, ins_load 0, load 0, done 0, error 0, cpu_hold 1.
REQ-031 After clear, byte_ready SHALL be 1 in the cycle after reset is released.
REQ-032 clear mid-image (any state) SHALL abandon the image; words already written stay in instruction memory; no load pulse in or after the reset cycle.
REQ-033 clear has priority over a simultaneous byte transfer; that byte is dropped.

Verification
REQ-034 Stream 00 02 20 13 00 14 27 -> load at l_addr 0 with ins_load 2013, at l_addr 2 with 0014; done=1, cpu_hold=0, error=0.
REQ-035 Stream 00 01 AB CD 00 (bad checksum, expected 66) -> one load (addr 0, ABCD); error=1, done=0, cpu_hold=1.
REQ-036 Stream 00 21 (N=33) -> no load; error=1 right after the count low byte; byte_ready=0.
REQ-037 Stream 00 00 00 -> no load; done=1.
REQ-038 byte_valid toggled randomly with a good 32-word image -> 32 loads at addresses 0..62 step 2; done=1; no byte lost or duplicated.
REQ-039 clear asserted in INS_LO of word 3, then a good 1-word image -> l_addr restarts at 0; done=1.

Source files
------------

// File: rtl/ins_bootloader.sv
// Boot-stream loader: parses a counted byte stream of 16-bit instruction words,
// writes them to instruction memory and releases the CPU only on a good checksum.
module ins_bootloader #(
    parameter int          MAX_WORDS = 32,
    parameter logic [15:0] BASE_ADDR = 16'd0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] ins_load,
    output logic [15:0] l_addr,
    output logic        load,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [2:0]  o_dbg_state
);

    // Handshake: a byte moves only in a cycle where byte_valid and byte_ready are
    // both high at the rising edge; byte_ready never depends on byte_valid.
    typedef enum logic [2:0] {
        S_CNT_HI = 3'd0,
        S_CNT_LO = 3'd1,
        S_INS_HI = 3'd2,
        S_INS_LO = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_count;
    logic [15:0] r_words;
    logic [7:0]  r_csum;
    logic [15:0] r_ins;
    logic [15:0] r_addr;
    logic        r_ready;
    logic        r_load;
    logic        r_hold;
    logic        r_done;
    logic        r_err;

    logic        w_xfer;
    logic [15:0] w_count_in;
    logic [15:0] w_words_inc;

    assign w_xfer      = byte_valid & r_ready;
    assign w_count_in  = {r_cnt_hi, byte_in};
    assign w_words_inc = r_words + 16'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CNT_HI: if (w_xfer) w_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_xfer) begin
                    if (w_count_in > MAX_W16)
                        w_next = S_ERR;
                    else if (w_count_in == 16'd0)
                        w_next = S_CSUM;
                    else
                        w_next = S_INS_HI;
                end
            end
            S_INS_HI: if (w_xfer) w_next = S_INS_LO;
            S_INS_LO: if (w_xfer) w_next = S_WRITE;
            S_WRITE:  w_next = (w_words_inc < r_count) ? S_INS_HI : S_CSUM;
            S_CSUM: begin
                if (w_xfer)
                    w_next = (byte_in == r_csum) ? S_DONE : S_ERR;
            end
            S_DONE:   w_next = S_DONE;
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_ERR;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up
    // with the state they describe.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= S_CNT_HI;
            r_cnt_hi <= 8'd0;
            r_count  <= 16'd0;
            r_words  <= 16'd0;
            r_csum   <= 8'd0;
            r_ins    <= 16'd0;
            r_addr   <= BASE_ADDR;
            r_ready  <= 1'b1;
            r_load   <= 1'b0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next inside {S_CNT_HI, S_CNT_LO, S_INS_HI, S_INS_LO, S_CSUM});
            r_load  <= (w_next == S_WRITE);
            r_hold  <= (w_next != S_DONE);
            r_done  <= (w_next == S_DONE);
            r_err   <= (w_next == S_ERR);
            case (r_state)
                S_CNT_HI: if (w_xfer) r_cnt_hi <= byte_in;
                S_CNT_LO: if (w_xfer) r_count <= w_count_in;
                S_INS_HI: begin
                    if (w_xfer) begin
                        r_ins  <= {byte_in, r_ins[7:0]};
                        r_csum <= r_csum ^ byte_in;
                    end
                end
                S_INS_LO: begin
                    if (w_xfer) begin
                        r_ins  <= {r_ins[15:8], byte_in};
                        r_csum <= r_csum ^ byte_in;
                    end
                end
                // Address advances after the strobe so it is stable during the write.
                S_WRITE: begin
                    r_words <= w_words_inc;
                    r_addr  <= r_addr + 16'd2;
                end
                default: ;
            endcase
        end
    end

    assign byte_ready  = r_ready;
    assign ins_load    = r_ins;
    assign l_addr      = r_addr;
    assign load        = r_load;
    assign cpu_hold    = r_hold;
    assign done        = r_done;
    assign error       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ins_bootloader.sv
// Randomized bench for ins_bootloader: a stream model predicts every memory write
// and the final done/error/hold outcome of each boot image.
module tb_ins_bootloader;

    localparam int          MAX_WORDS = 32;
    localparam logic [15:0] BASE      = 16'd0;

    logic        clock = 1'b0;
    logic        clear;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] ins_load;
    logic [15:0] l_addr;
    logic        load;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];
    logic [15:0] img_q[$];

    ins_bootloader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE)) dut (
        .clock      (clock),
        .clear      (clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ins_load   (ins_load),
        .l_addr     (l_addr),
        .load       (load),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .o_dbg_state(dbg_state)
    );

    // ---- clock / watchdog ----
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---- scoreboard: every load pulse must match the next predicted write ----
    always @(negedge clock) begin
        if (load !== 1'b0) begin
            if (exp_q.size() == 0) begin
                $display("note: unexpected load at addr %0h data %0h (state %0d)", l_addr, ins_load, dbg_state);
                check("unexpected_load", 32'(load), 32'd0);
            end else begin
                check("load_write", {l_addr, ins_load}, exp_q.pop_front());
            end
        end
    end

    // ---- driver tasks ----
    task automatic do_reset(input logic valid_during);
        @(negedge clock);
        exp_q.delete();
        clear      = 1'b1;
        byte_valid = valid_during;
        byte_in    = 8'($urandom);
        @(negedge clock);
        clear      = 1'b0;
        byte_valid = 1'b0;
        check("reset_addr_ins", {l_addr, ins_load}, {BASE, 16'h0000});
        // {byte_ready, load, done, error, cpu_hold}
        check("reset_flags", {27'd0, byte_ready, load, done, error, cpu_hold}, 32'b10001);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int idle;
        bit sent;
        sent = 1'b0;
        if (gaps) begin
            idle = $urandom_range(0, 3);
            repeat (idle) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                @(negedge clock);
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 20 && !sent; t++) begin
            if (byte_ready) sent = 1'b1;
            @(negedge clock);
        end
        byte_valid = 1'b0;
        if (!sent) begin
            n_total++;
            $display("FAIL send_timeout: byte %0h not accepted, got ready=0 required ready=1", b);
        end
    endtask

    // Model: N words from img_q land at BASE+2i; image good iff N<=MAX and the
    // trailing byte equals the XOR of all instruction bytes.
    task automatic run_image(input logic [15:0] n, input logic [7:0] csum_xor, input bit gaps);
        logic [7:0] cs;
        logic [4:0] want;
        cs = 8'd0;
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        if (n > 16'(MAX_WORDS)) begin
            check("oversize_flags", {27'd0, byte_ready, load, done, error, cpu_hold}, 32'b00011);
            want = 5'b00011;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({BASE + 16'(2 * i), img_q[i]});
                cs = cs ^ img_q[i][15:8] ^ img_q[i][7:0];
                send_byte(img_q[i][15:8], gaps);
                send_byte(img_q[i][7:0], gaps);
            end
            send_byte(cs ^ csum_xor, gaps);
            want = (csum_xor == 8'd0) ? 5'b00100 : 5'b00011;
            check("final_flags", {27'd0, byte_ready, load, done, error, cpu_hold}, {27'd0, want});
            check("loads_left", 32'(exp_q.size()), 32'd0);
        end
        // Terminal states must ignore further traffic.
        repeat (4) begin
            byte_in    = 8'($urandom);
            byte_valid = 1'b1;
            @(negedge clock);
        end
        byte_valid = 1'b0;
        check("terminal_flags", {27'd0, byte_ready, load, done, error, cpu_hold}, {27'd0, want});
    endtask

    // ---- stimulus ----
    initial begin
        logic [15:0] n;
        logic [7:0]  bad;
        clear      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        repeat (2) @(negedge clock);

        // Two-word good image (stream 00 02 20 13 00 14 27).
        do_reset(1'b0);
        img_q = '{16'h2013, 16'h0014};
        run_image(16'd2, 8'h00, 1'b0);

        // One word with checksum byte 00 instead of 66.
        do_reset(1'b0);
        img_q = '{16'hABCD};
        run_image(16'd1, 8'h66, 1'b0);

        // Oversize count 33.
        do_reset(1'b0);
        run_image(16'd33, 8'h00, 1'b0);

        // Empty image (00 00 00).
        do_reset(1'b0);
        run_image(16'd0, 8'h00, 1'b0);

        // Full 32-word image with random valid gaps.
        do_reset(1'b0);
        img_q.delete();
        for (int i = 0; i < 32; i++) img_q.push_back(16'($urandom));
        run_image(16'd32, 8'h00, 1'b1);

        // Clear in INS_LO of word 3 with a byte offered, then a good 1-word image.
        do_reset(1'b0);
        img_q.delete();
        for (int i = 0; i < 5; i++) img_q.push_back(16'($urandom));
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({BASE + 16'(2 * i), img_q[i]});
            send_byte(img_q[i][15:8], 1'b0);
            send_byte(img_q[i][7:0], 1'b0);
        end
        send_byte(img_q[3][15:8], 1'b0);
        check("pre_clear_loads", 32'(exp_q.size()), 32'd0);
        byte_in = img_q[3][7:0];
        do_reset(1'b1);
        repeat (2) @(negedge clock);
        img_q = '{16'h1234};
        run_image(16'd1, 8'h00, 1'b0);

        // Random images: sizes around the limit, occasional bad checksum.
        for (int k = 0; k < 6; k++) begin
            do_reset(1'b0);
            n   = 16'($urandom_range(0, MAX_WORDS + 3));
            bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            img_q.delete();
            for (int i = 0; i < int'(n); i++) img_q.push_back(16'($urandom));
            run_image(n, bad, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
